core_scheduler: RTL and testbench

- Per-core control FSM; sits directly downstream of the block dispatcher, one instance per core.
- Consumes one core's start/reset/thread-count triple from the dispatcher and sequences that block's threads through FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE in lock-step, sharing one PC across all lanes.
- Raises done on RET; the dispatcher uses done to reset the core and issue the next block.

---
 rtl/gpu_pkg.sv | 30 +++
 rtl/lsu_busy_reduce.sv | 29 ++
 rtl/core_scheduler.sv | 106 ++++++++++
 tb/tb_core_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpu_pkg                                                              |
// | Shared core-scheduler and LSU state encodings, default PC width.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gpu_pkg;

  localparam int PC_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    REQUEST = 3'd3,
    WAIT    = 3'd4,
    EXECUTE = 3'd5,
    UPDATE  = 3'd6,
    DONE    = 3'd7
  } core_state_t;

  typedef enum logic [1:0] {
    L_IDLE       = 2'd0,
    L_REQUESTING = 2'd1,
    L_WAITING    = 2'd2,
    L_DONE       = 2'd3
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_busy_reduce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_busy_reduce                                                      |
// | High while any active lane's LSU is still requesting or waiting.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lsu_busy_reduce
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic [THREADS_PER_BLOCK-1:0][1:0]     lsu_state,
  input  logic [$clog2(THREADS_PER_BLOCK):0]    active_count,
  output logic                                  busy
);

  localparam int c_cnt_w = $clog2(THREADS_PER_BLOCK) + 1;

  logic [THREADS_PER_BLOCK-1:0] w_lane_busy;

  for (genvar i = 0; i < THREADS_PER_BLOCK; i++) begin : g_lane
    assign w_lane_busy[i] = (c_cnt_w'(i) < active_count) &&
                            ((lsu_state[i] == L_REQUESTING) || (lsu_state[i] == L_WAITING));
  end

  assign busy = |w_lane_busy;

endmodule
`default_nettype wire

// File: rtl/core_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_scheduler                                                       |
// | Per-core lock-step control FSM sequencing one block's threads.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_W              = PC_W_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]    thread_count,
  input  logic                                  fetch_done,
  input  logic                                  decoded_mem_read,
  input  logic                                  decoded_mem_write,
  input  logic                                  decoded_ret,
  input  logic [THREADS_PER_BLOCK-1:0][1:0]     lsu_state,
  input  logic [THREADS_PER_BLOCK-1:0][PC_W-1:0] next_pc,
  output logic [2:0]                            core_state,
  output logic [PC_W-1:0]                       current_pc,
  output logic                                  done
);

  localparam int c_cnt_w = $clog2(THREADS_PER_BLOCK) + 1;
  localparam int c_idx_w = (THREADS_PER_BLOCK > 1) ? $clog2(THREADS_PER_BLOCK) : 1;

  core_state_t        r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pc, w_pc_nxt;
  logic               r_done, w_done_nxt;
  logic [c_cnt_w-1:0] w_eff_count;
  logic [c_idx_w-1:0] w_last_lane;
  logic               w_busy;
  logic               w_unused;

  // Memory-op flags only shape the LSU behaviour; WAIT looks at lane state alone.
  assign w_unused = decoded_mem_read ^ decoded_mem_write;

  assign w_eff_count = (thread_count > c_cnt_w'(THREADS_PER_BLOCK)) ?
                       c_cnt_w'(THREADS_PER_BLOCK) : thread_count;
  assign w_last_lane = (w_eff_count == '0) ? '0 : c_idx_w'(w_eff_count - c_cnt_w'(1));

  lsu_busy_reduce #(
    .THREADS_PER_BLOCK (THREADS_PER_BLOCK)
  ) u_busy (
    .lsu_state    (lsu_state),
    .active_count (w_eff_count),
    .busy         (w_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_done_nxt  = r_done;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_eff_count == '0) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = FETCH;
          end
        end
      end
      FETCH:   if (fetch_done) w_state_nxt = DECODE;
      DECODE:  w_state_nxt = REQUEST;
      REQUEST: w_state_nxt = WAIT;
      WAIT:    if (!w_busy) w_state_nxt = EXECUTE;
      EXECUTE: w_state_nxt = UPDATE;
      UPDATE: begin
        if (decoded_ret) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          // Lanes are assumed convergent; the last active lane's PC stands for all.
          w_pc_nxt    = next_pc[w_last_lane];
          w_state_nxt = FETCH;
        end
      end
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign core_state = r_state;
  assign current_pc = r_pc;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_core_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_core_scheduler                                                    |
// | Block-level schedule generator, scoreboard and monitor.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_core_scheduler;
  import gpu_pkg::*;

  logic            clk = 1'b0;
  logic            reset, start, fetch_done;
  logic            decoded_mem_read, decoded_mem_write, decoded_ret;
  logic [2:0]      thread_count;
  logic [3:0][1:0] lsu_state;
  logic [3:0][7:0] next_pc;
  logic [2:0]      core_state;
  logic [7:0]      current_pc;
  logic            done;

  core_scheduler #(.THREADS_PER_BLOCK(4), .PC_W(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .thread_count      (thread_count),
    .fetch_done        (fetch_done),
    .decoded_mem_read  (decoded_mem_read),
    .decoded_mem_write (decoded_mem_write),
    .decoded_ret       (decoded_ret),
    .lsu_state         (lsu_state),
    .next_pc           (next_pc),
    .core_state        (core_state),
    .current_pc        (current_pc),
    .done              (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              rst, start, fd, rd, wr, ret, chk;
    logic [2:0]      tc;
    logic [3:0][1:0] lsu;
    logic [3:0][7:0] npc;
    logic [2:0]      exp_st;
    logic [7:0]      exp_pc;
    bit              exp_done;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic [7:0] pc;
    bit         dn;
  } exp_t;

  vec_t sched[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // One cycle with every input randomised; callers pin the inputs that matter.
  function automatic vec_t rnd(input logic [2:0] st, input logic [7:0] pc,
                               input bit dn, input int tc);
    vec_t v;
    v.rst   = 1'b0;
    v.start = 1'($urandom);
    v.fd    = 1'($urandom);
    v.rd    = 1'($urandom);
    v.wr    = 1'($urandom);
    v.ret   = 1'($urandom);
    v.chk   = 1'b1;
    v.tc    = 3'(tc);
    for (int l = 0; l < 4; l++) begin
      v.lsu[l] = 2'($urandom);
      v.npc[l] = 8'($urandom);
    end
    v.exp_st   = st;
    v.exp_pc   = pc;
    v.exp_done = dn;
    return v;
  endfunction

  // Expand one block (program description) into its cycle-by-cycle schedule.
  // abort_mode: 0 none, 1 reset at a random cycle, 2 reset on the first WAIT at pc 5.
  task automatic gen_block(input int tc, input int n_instr, input bit seq,
                           input int max_fetch, input int max_stall, input int abort_mode);
    vec_t       blk[$];
    vec_t       v;
    int         eff, cut, ms, f;
    int         s[4];
    bit         mem, rd, last;
    logic [7:0] pc;
    eff = (tc > 4) ? 4 : tc;
    pc  = 8'd0;
    cut = -1;
    repeat ($urandom_range(0, 2)) begin
      v = rnd(IDLE, pc, 1'b0, tc); v.start = 1'b0; blk.push_back(v);
    end
    v = rnd(IDLE, pc, 1'b0, tc); v.start = 1'b1; blk.push_back(v);
    if (eff > 0) begin
      for (int i = 0; i < n_instr; i++) begin
        last = (i == n_instr - 1);
        mem  = (max_stall > 0) && ($urandom_range(0, 1) == 1);
        rd   = 1'($urandom_range(0, 1));
        ms   = 0;
        for (int l = 0; l < 4; l++) begin
          s[l] = mem ? int'($urandom_range(0, max_stall)) : 0;
          if (l < eff && s[l] > ms) ms = s[l];
        end
        f = $urandom_range(0, max_fetch);
        for (int j = 0; j <= f; j++) begin
          v = rnd(FETCH, pc, 1'b0, tc); v.fd = (j == f); blk.push_back(v);
        end
        v = rnd(DECODE, pc, 1'b0, tc);
        v.rd = mem && rd; v.wr = mem && !rd; v.ret = last; blk.push_back(v);
        v = rnd(REQUEST, pc, 1'b0, tc);
        v.rd = mem && rd; v.wr = mem && !rd; v.ret = last;
        for (int l = 0; l < eff; l++) v.lsu[l] = mem ? L_REQUESTING : L_IDLE;
        blk.push_back(v);
        for (int j = 0; j <= ms; j++) begin
          v = rnd(WAIT, pc, 1'b0, tc);
          v.rd = mem && rd; v.wr = mem && !rd; v.ret = last;
          for (int l = 0; l < eff; l++) begin
            if (!mem)          v.lsu[l] = L_IDLE;
            else if (j < s[l]) v.lsu[l] = (j == 0) ? L_REQUESTING : L_WAITING;
            else               v.lsu[l] = L_DONE;
          end
          if (abort_mode == 2 && pc == 8'd5 && cut < 0) cut = blk.size();
          blk.push_back(v);
        end
        v = rnd(EXECUTE, pc, 1'b0, tc);
        v.rd = mem && rd; v.wr = mem && !rd; v.ret = last; blk.push_back(v);
        v = rnd(UPDATE, pc, 1'b0, tc);
        v.rd = mem && rd; v.wr = mem && !rd; v.ret = last;
        if (seq) for (int l = 0; l < 4; l++) v.npc[l] = pc + 8'd1;
        blk.push_back(v);
        if (!last) pc = v.npc[eff - 1];
      end
    end
    repeat ($urandom_range(1, 3)) blk.push_back(rnd(DONE, pc, 1'b1, tc));
    v = rnd(DONE, pc, 1'b1, tc); v.rst = 1'b1; blk.push_back(v);
    if (abort_mode == 1) cut = $urandom_range(1, blk.size() - 2);
    if (cut >= 0) begin
      while (blk.size() > cut + 1) void'(blk.pop_back());
      blk[cut].rst = 1'b1;
    end
    foreach (blk[k]) sched.push_back(blk[k]);
  endtask

  // Monitor: outputs settle after the posedge, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_vec++;
        if (core_state !== e.st || current_pc !== e.pc || done !== e.dn) begin
          n_err++;
          $display("FAIL state/pc/done @%0t: got st=%0d pc=%0d done=%0d, want st=%0d pc=%0d done=%0d",
                   $time, core_state, current_pc, done, e.st, e.pc, e.dn);
        end
      end
    end
  end

  initial begin
    vec_t v;
    exp_t e;
    reset = 1'b1; start = 1'b0; fetch_done = 1'b0; thread_count = 3'd0;
    decoded_mem_read = 1'b0; decoded_mem_write = 1'b0; decoded_ret = 1'b0;
    lsu_state = '0; next_pc = '0;

    v = rnd(IDLE, 8'd0, 1'b0, 0); v.rst = 1'b1; v.chk = 1'b0; sched.push_back(v);
    gen_block(4, 4, 1'b1, 0, 0, 0);   // straight line, RET at pc 3
    gen_block(4, 2, 1'b0, 0, 5, 0);   // memory stalls
    gen_block(2, 3, 1'b0, 1, 5, 0);   // inactive lanes ignored
    gen_block(0, 1, 1'b0, 0, 0, 0);   // zero count
    gen_block(7, 3, 1'b1, 0, 2, 0);   // oversize count
    gen_block(4, 8, 1'b1, 0, 0, 2);   // reset mid-WAIT at pc 5
    gen_block(4, 3, 1'b1, 0, 0, 0);   // restart from pc 0
    gen_block(3, 2, 1'b0, 3, 0, 0);   // slow fetch
    for (int b = 0; b < 40; b++)
      gen_block($urandom_range(0, 7), $urandom_range(1, 5), 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 5), ($urandom_range(0, 4) == 0) ? 1 : 0);

    foreach (sched[i]) begin
      @(posedge clk);
      #1;
      v = sched[i];
      reset             = v.rst;
      start             = v.start;
      thread_count      = v.tc;
      fetch_done        = v.fd;
      decoded_mem_read  = v.rd;
      decoded_mem_write = v.wr;
      decoded_ret       = v.ret;
      lsu_state         = v.lsu;
      next_pc           = v.npc;
      if (v.chk) begin
        e.st = v.exp_st; e.pc = v.exp_pc; e.dn = v.exp_done;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
